// File: rtl/enc8b10b_pkg.sv
// rtl/enc8b10b_pkg.sv - 8b/10b code tables, valid-K list and running-disparity constants
package enc8b10b_pkg;

    localparam logic RD_NEG = 1'b0;
    localparam logic RD_POS = 1'b1;

    // abcdei sub-blocks as emitted from RD-, indexed by EDCBA
    localparam logic [5:0] ENC6_NEG [0:31] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    localparam logic [5:0] K28_6B_NEG = 6'b001111;
    // D7 is neutral yet still has distinct RD-/RD+ forms
    localparam logic [5:0] D7_6B_NEG  = 6'b111000;

    // fghj sub-blocks for RD- after the 6b sub-block, indexed by HGF
    localparam logic [3:0] ENC4_NEG [0:7] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110, 4'b1110
    };
    localparam logic [3:0] K4_NEG [0:7] = '{
        4'b1011, 4'b0110, 4'b1010, 4'b1100,
        4'b1101, 4'b0101, 4'b1001, 4'b0111
    };
    localparam logic [3:0] A7_NEG = 4'b0111;

    localparam int NUM_VALID_K = 12;
    localparam logic [7:0] VALID_K [0:NUM_VALID_K-1] = '{
        8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
        8'hF7, 8'hFB, 8'hFD, 8'hFE
    };

    function automatic logic is_valid_k(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_VALID_K; i++) begin
            if (b == VALID_K[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// rtl/enc8b10b_lane.sv - combinational single-lane 8b/10b encoder with running-disparity update
module enc8b10b_lane
    import enc8b10b_pkg::*;
(
    input  logic [7:0] din,
    input  logic       kin,
    input  logic       force_neg,
    input  logic       rd_in,
    output logic [9:0] code,
    output logic       rd_out,
    output logic       kerr
);

    logic       rd_start;
    logic       rd_mid;
    logic       kvalid;
    logic       ksel;
    logic       unbal6;
    logic       unbal4;
    logic       flip4;
    logic [5:0] c6n;
    logic [5:0] c6;
    logic [3:0] c4n;
    logic [3:0] c4;

    always_comb begin
        rd_start = force_neg ? RD_NEG : rd_in;
        kvalid   = is_valid_k(din);
        ksel     = kin && kvalid;
        kerr     = kin && !kvalid;

        c6n    = (ksel && din[4:0] == 5'd28) ? K28_6B_NEG : ENC6_NEG[din[4:0]];
        unbal6 = ($countones(c6n) != 3);
        c6     = (rd_start == RD_POS && (unbal6 || c6n == D7_6B_NEG)) ? ~c6n : c6n;
        rd_mid = unbal6 ? ~rd_start : rd_start;

        // K codes and A7 invert in full at RD+; plain data only inverts unbalanced codes and x.3
        flip4 = (rd_mid == RD_POS);
        if (ksel) begin
            c4n = K4_NEG[din[7:5]];
        end else if (din[7:5] == 3'd7 &&
                     ((rd_mid == RD_NEG && c6[1:0] == 2'b11) ||
                      (rd_mid == RD_POS && c6[1:0] == 2'b00))) begin
            c4n = A7_NEG;
        end else begin
            c4n   = ENC4_NEG[din[7:5]];
            flip4 = (rd_mid == RD_POS) && (($countones(c4n) != 2) || din[7:5] == 3'd3);
        end
        unbal4 = ($countones(c4n) != 2);
        c4     = flip4 ? ~c4n : c4n;

        rd_out = unbal4 ? ~rd_mid : rd_mid;
        code   = {c6, c4};
    end

endmodule

// File: rtl/enc8b10b_multilane.sv
// rtl/enc8b10b_multilane.sv - two-stage ready/valid multi-lane 8b/10b encoder; ENC8B10B_KCHECK_EN adds oKErr
module enc8b10b_multilane
    import enc8b10b_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic                  INTERCLK,
    input  logic                  Reset,
    input  logic                  iValid,
    output logic                  iReady,
    input  logic [8*LANES-1:0]    iData,
    input  logic [LANES-1:0]      TXDATAK,
    input  logic                  TXCOMP,
    output logic                  oValid,
    input  logic                  oReady,
    output logic [10*LANES-1:0]   oData,
    output logic [LANES-1:0]      oKErr
);

    logic                  ready_en;
    logic                  s1_valid;
    logic [8*LANES-1:0]    s1_data;
    logic [LANES-1:0]      s1_k;
    logic                  s1_comp;
    logic [LANES-1:0]      rd;
    logic [LANES-1:0]      rd_next;
    logic [LANES-1:0]      lane_kerr;
    logic [10*LANES-1:0]   enc_data;
    logic                  s1_adv;
    logic                  accept;

    assign s1_adv = s1_valid && (!oValid || oReady);
    // ready_en keeps iReady low during reset and for the first cycle after release
    assign iReady = ready_en && (!s1_valid || !oValid || oReady);
    assign accept = iValid && iReady;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        enc8b10b_lane u_lane (
            .din       (s1_data[8*g +: 8]),
            .kin       (s1_k[g]),
            .force_neg (s1_comp),
            .rd_in     (rd[g]),
            .code      (enc_data[10*g +: 10]),
            .rd_out    (rd_next[g]),
            .kerr      (lane_kerr[g])
        );
    end

    always_ff @(posedge INTERCLK or negedge Reset) begin
        if (!Reset) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_k     <= '0;
            s1_comp  <= 1'b0;
            oValid   <= 1'b0;
            oData    <= '0;
            rd       <= {LANES{RD_NEG}};
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= iData;
                s1_k     <= TXDATAK;
                s1_comp  <= TXCOMP;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                oValid <= 1'b1;
                oData  <= enc_data;
                rd     <= rd_next;
            end else if (oReady) begin
                oValid <= 1'b0;
            end
        end
    end

`ifdef ENC8B10B_KCHECK_EN
    always_ff @(posedge INTERCLK or negedge Reset) begin
        if (!Reset) begin
            oKErr <= '0;
        end else if (s1_adv) begin
            oKErr <= lane_kerr;
        end
    end
`else
    logic unused_kerr;
    assign unused_kerr = ^lane_kerr;
    assign oKErr       = '0;
`endif

endmodule

// File: tb/tb_enc8b10b_multilane.sv
// tb/tb_enc8b10b_multilane.sv - directed two-lane bench with hand-computed 10b symbols
module tb_enc8b10b_multilane;

    localparam int LANES = 2;
    localparam logic [9:0] K285N = 10'b0011111010;
    localparam logic [9:0] K285P = 10'b1100000101;
    localparam logic [9:0] D215  = 10'b1010101010;
`ifdef ENC8B10B_KCHECK_EN
    localparam logic KE = 1'b1;
`else
    localparam logic KE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ivalid;
    logic          iready;
    logic [15:0]   idata;
    logic [1:0]    txk;
    logic          txcomp;
    logic          ovalid;
    logic          oready;
    logic [19:0]   odata;
    logic [1:0]    okerr;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [21:0]   exp_q[$];
    int            exp_idx = 0;
    logic          chk_en = 1'b0;

    logic [7:0] bp_byte [0:7] = '{8'hB5, 8'h4A, 8'h23, 8'hC5, 8'hA9, 8'h2C, 8'hD3, 8'h59};
    logic [9:0] bp_code [0:7] = '{10'b1010101010, 10'b0101010101, 10'b1100011001, 10'b1010010110,
                                  10'b1001011010, 10'b0011011001, 10'b1100100110, 10'b1001100101};

    always #5 clk = ~clk;

    enc8b10b_multilane #(.LANES(LANES)) dut (
        .INTERCLK (clk),
        .Reset    (rst_n),
        .iValid   (ivalid),
        .iReady   (iready),
        .iData    (idata),
        .TXDATAK  (txk),
        .TXCOMP   (txcomp),
        .oValid   (ovalid),
        .oReady   (oready),
        .oData    (odata),
        .oKErr    (okerr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_beat(input logic [1:0] ke, input logic [9:0] l1, input logic [9:0] l0);
        exp_q.push_back({ke, l1, l0});
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic c);
        logic hs;
        int   t;
        idata  = d;
        txk    = k;
        txcomp = c;
        ivalid = 1'b1;
        hs     = 1'b0;
        t      = 0;
        while (!hs && t < 50) begin
            @(negedge clk);
            hs = iready;
            @(posedge clk);
            #1;
            t++;
        end
        ivalid = 1'b0;
        check("accept", {31'd0, hs}, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_idx < exp_q.size() && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain", exp_idx, exp_q.size());
    endtask

    // Every cycle with oValid high is compared, so stalled symbols must hold the expected value
    always @(negedge clk) begin
        if (chk_en && rst_n && ovalid) begin
            if (exp_idx < exp_q.size()) begin
                check($sformatf("beat%0d", exp_idx), {10'd0, okerr, odata}, {10'd0, exp_q[exp_idx]});
                if (oready) exp_idx++;
            end else begin
                check("extra_beat", {31'd0, ovalid}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        ivalid = 1'b0;
        idata  = '0;
        txk    = '0;
        txcomp = 1'b0;
        oready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_iready", {31'd0, iready}, 32'd0);
        check("rst_ovalid", {31'd0, ovalid}, 32'd0);
        check("rst_odata",  {12'd0, odata},  32'd0);
        check("rst_okerr",  {30'd0, okerr},  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("iready_after_rst", {31'd0, iready}, 32'd1);
        chk_en = 1'b1;

        // K28.5 run on lane 0, D21.5 on lane 1
        expect_beat(2'b00, D215, K285N);
        expect_beat(2'b00, D215, K285P);
        send({8'hB5, 8'hBC}, 2'b01, 1'b0);
        send({8'hB5, 8'hBC}, 2'b01, 1'b0);
        drain();

        // alternate A7 selection, then compliance from RD+
        expect_beat(2'b00, D215, 10'b1000110111);
        expect_beat(2'b00, D215, 10'b1101001000);
        expect_beat(2'b00, D215, 10'b1110001110);
        expect_beat(2'b00, D215, K285N);
        expect_beat(2'b00, D215, K285P);
        send({8'hB5, 8'hF1}, 2'b00, 1'b0);
        send({8'hB5, 8'hEB}, 2'b00, 1'b0);
        send({8'hB5, 8'hE7}, 2'b00, 1'b0);
        send({8'hB5, 8'hBC}, 2'b01, 1'b1);
        send({8'hB5, 8'hBC}, 2'b01, 1'b0);
        drain();

        // invalid K 0x00 on lane 0 encodes as D0.0
        expect_beat({1'b0, KE}, D215, 10'b1001110100);
        send({8'hB5, 8'h00}, 2'b01, 1'b0);
        drain();

        // backpressure: lane 0 distinct neutral data, lane 1 K28.5 alternating
        for (int i = 0; i < 8; i++) begin
            expect_beat(2'b00, (i % 2 == 0) ? K285N : K285P, bp_code[i]);
        end
        fork
            begin
                for (int i = 0; i < 8; i++) send({8'hBC, bp_byte[i]}, 2'b10, 1'b0);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk);
                    #1;
                    oready = ~oready;
                end
            end
        join
        oready = 1'b1;
        drain();

        // reset mid-stream with both stages full and lane 0 at RD+
        chk_en = 1'b0;
        send({8'hB5, 8'hBC}, 2'b01, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        oready = 1'b0;
        send({8'hB5, 8'h4A}, 2'b00, 1'b0);
        send({8'hB5, 8'h23}, 2'b00, 1'b0);
        @(negedge clk);
        check("prerst_ovalid", {31'd0, ovalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_ovalid", {31'd0, ovalid}, 32'd0);
        check("midrst_iready", {31'd0, iready}, 32'd0);
        check("midrst_odata",  {12'd0, odata},  32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        exp_idx = 0;
        oready  = 1'b1;
        @(posedge clk);
        #1;
        check("iready_after_midrst", {31'd0, iready}, 32'd1);
        chk_en = 1'b1;
        expect_beat(2'b00, D215, K285N);
        send({8'hB5, 8'hBC}, 2'b01, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
